// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared opcodes, FSM states and sizing for the ALU controller
package alu_ctrl_pkg;
  localparam int NREG = 4;
  localparam int AW = $clog2(NREG);
  localparam logic [2:0] OP_SUB_AB = 3'b000;
  localparam logic [2:0] OP_SUB_BA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT_C = 3'b110;
  localparam logic [2:0] OP_LOAD = 3'b111;
  typedef enum logic [2:0] {INIT, IDLE, ISSUE, CAPTURE, DONE} state_t;
endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: command and response valid/ready channels of the ALU controller
interface alu_ctrl_if #(parameter int AW = 2);
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_src_a;
  logic [AW-1:0] cmd_src_b;
  logic [3:0] cmd_imm;
  logic res_valid;
  logic res_ready;
  logic [3:0] res_data;
  logic res_ovr;
  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm, res_ready,
    input cmd_ready, res_valid, res_data, res_ovr
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm, res_ready,
    output cmd_ready, res_valid, res_data, res_ovr
  );
endinterface

// File: rtl/alu_ctrl_regfile.sv
// alu_ctrl_regfile: NREG x 4-bit registers, one write port, two operand reads, one debug read
module alu_ctrl_regfile #(
  parameter int NREG = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rdata_a,
  output logic [3:0]    rdata_b,
  output logic [3:0]    rd_data
);
  logic [3:0] regs [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (we)
      regs[waddr] <= wdata;
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rd_data = regs[rd_addr];
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: command-driven controller that issues operands to an external 4-bit ALU,
// writes the result back to the register file and returns it on a response channel.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NREG = alu_ctrl_pkg::NREG,
  parameter int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_if.slave     bus,
  output logic [2:0]    alu_sel,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [3:0]    alu_c,
  input  logic [3:0]    alu_out,
  input  logic          alu_ovr,
  output logic          ovr_flag,
  input  logic          clr_flag,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data
);
  state_t state, state_n;
  logic [2:0] op;
  logic [AW-1:0] dst, src_a, src_b;
  logic [3:0] imm, rdata_a, rdata_b, result;
  logic hs, done, we, rov;
  assign hs = bus.cmd_valid && bus.cmd_ready;
  assign done = bus.res_valid && bus.res_ready;
  assign we = state == CAPTURE;
  assign result = (op == OP_LOAD) ? imm : alu_out;
  assign rov = (op != OP_LOAD) && alu_ovr;
  alu_ctrl_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(dst), .wdata(result),
    .raddr_a(src_a), .raddr_b(src_b), .rd_addr(rd_addr),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rd_data(rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_n;
  always_comb begin
    state_n = (state == INIT)          ? IDLE :
              (state == IDLE && hs)    ? ISSUE :
              (state == ISSUE)         ? CAPTURE :
              (state == CAPTURE)       ? DONE :
              (state == DONE && done)  ? IDLE : state;
  end
  // Handshake outputs are registered from the current state, so they lag state entry by one edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {op, dst, src_a, src_b, imm} <= '0;
      {alu_sel, alu_a, alu_b, alu_c} <= '0;
      bus.cmd_ready <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.res_ovr <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      if (hs) {op, dst, src_a, src_b, imm} <= {bus.cmd_op, bus.cmd_dst, bus.cmd_src_a, bus.cmd_src_b, bus.cmd_imm};
      if (state == ISSUE) {alu_sel, alu_a, alu_b, alu_c} <= {op, rdata_a, rdata_b, rdata_a};
      if (we) {bus.res_data, bus.res_ovr} <= {result, rov};
      bus.cmd_ready <= state == IDLE && !hs;
      bus.res_valid <= state == DONE && !done;
      ovr_flag <= (we && rov) ? 1'b1 : clr_flag ? 1'b0 : ovr_flag;
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed vectors for alu_ctrl with a behavioural 4-bit ALU alongside
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;
  logic clk = 0, rst_n = 0, alu_ovr, clr_flag = 0, ovr_flag;
  logic [2:0] alu_sel;
  logic [3:0] alu_a, alu_b, alu_c, alu_out, rd_data;
  logic [1:0] rd_addr = 0;
  int total = 0, passed = 0, lat;
  alu_ctrl_if #(.AW(2)) bus ();
  alu_ctrl #(.NREG(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_out(alu_out), .alu_ovr(alu_ovr), .ovr_flag(ovr_flag),
    .clr_flag(clr_flag), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  // Reference ALU: ovr is carry-out for ADD and borrow for the subtractions.
  always_comb begin
    logic [4:0] w;
    w = '0;
    case (alu_sel)
      OP_SUB_AB: w = {1'b0, alu_a} - {1'b0, alu_b};
      OP_SUB_BA: w = {1'b0, alu_b} - {1'b0, alu_a};
      OP_ADD:    w = {1'b0, alu_a} + {1'b0, alu_b};
      OP_AND:    w = {1'b0, alu_a & alu_b};
      OP_OR:     w = {1'b0, alu_a | alu_b};
      OP_XOR:    w = {1'b0, alu_a ^ alu_b};
      OP_NOT_C:  w = {1'b0, ~alu_c};
      default:   w = '0;
    endcase
    {alu_ovr, alu_out} = w;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic reset_release();
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1 chk("rdy_edge1", bus.cmd_ready, 0);
    @(posedge clk) #1 chk("rdy_edge2", bus.cmd_ready, 1);
  endtask
  task automatic issue(input logic [2:0] op, input logic [1:0] d, sa, sb, input logic [3:0] imm);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_dst = d;
    bus.cmd_src_a = sa; bus.cmd_src_b = sb; bus.cmd_imm = imm;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) chk("cmd_ready_wait", bus.cmd_ready, 1);
    @(posedge clk) #1 bus.cmd_valid = 0;
  endtask
  task automatic wait_res();
    lat = 0;
    while (!bus.res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic respond();
    @(negedge clk) bus.res_ready = 1;
    @(posedge clk) #1 bus.res_ready = 0;
    chk("res_valid_drop", bus.res_valid, 0);
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [1:0] d, sa, sb,
                     input logic [3:0] imm, input logic [3:0] exp_d, input logic exp_o);
    issue(op, d, sa, sb, imm);
    wait_res();
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_data"}, bus.res_data, exp_d);
    chk({tag, "_ovr"}, bus.res_ovr, exp_o);
    respond();
  endtask
  initial begin
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_dst = 0; bus.cmd_src_a = 0;
    bus.cmd_src_b = 0; bus.cmd_imm = 0; bus.res_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_ovr_flag", ovr_flag, 0);
    chk("rst_rd_data", rd_data, 0);
    reset_release();
    run("load_r0", OP_LOAD, 0, 0, 0, 4'd9, 4'd9, 0);
    run("load_r1", OP_LOAD, 1, 0, 0, 4'd12, 4'd12, 0);
    rd_addr = 1; #1 chk("rd_r1", rd_data, 12);
    run("add", OP_ADD, 2, 0, 1, 0, 4'd5, 1);
    chk("ovr_flag_add", ovr_flag, 1);
    run("sub_ab", OP_SUB_AB, 3, 0, 1, 0, 4'hD, 1);
    run("sub_ba", OP_SUB_BA, 3, 0, 1, 0, 4'd3, 0);
    run("not_c", OP_NOT_C, 0, 0, 1, 0, 4'd6, 0);
    rd_addr = 0; #1 chk("rd_r0", rd_data, 6);
    run("and", OP_AND, 2, 1, 2, 0, 4'd4, 0);
    run("xor", OP_XOR, 3, 1, 3, 0, 4'd15, 0);
    run("or", OP_OR, 3, 0, 2, 0, 4'd6, 0);
    issue(OP_LOAD, 3, 0, 0, 4'd7);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data", bus.res_data, 7);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
    end
    respond();
    @(negedge clk) clr_flag = 1;
    @(posedge clk) #1 clr_flag = 0;
    chk("clr_flag", ovr_flag, 0);
    issue(OP_ADD, 2, 1, 1, 0);
    @(posedge clk) #1 clr_flag = 1;
    @(posedge clk) #1 clr_flag = 0;
    chk("set_wins", ovr_flag, 1);
    wait_res();
    chk("add2_data", bus.res_data, 8);
    chk("add2_ovr", bus.res_ovr, 1);
    respond();
    rd_addr = 2; #1 chk("rd_r2_pre", rd_data, 8);
    issue(OP_ADD, 2, 0, 1, 0);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    chk("mid_rst_res_data", bus.res_data, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_ovr_flag", ovr_flag, 0);
    chk("mid_rst_r2", rd_data, 0);
    reset_release();
    for (int i = 0; i < 5; i++) @(posedge clk) #1 chk("no_stale_res", bus.res_valid, 0);
    chk("post_rst_r2", rd_data, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
